// File: rtl/fetch_queue.sv
// In-order instruction queue between the fetch buffer and decode. It classifies each
// word as compressed or full-length and presents the head entry as a valid/ready stream.
module fetch_queue #(
  parameter int PA_BITS = 56,
  parameter int WORDLEN = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       FlushD,
  input  logic                       FetchValid,
  input  logic [WORDLEN-1:0]         FetchWord,
  input  logic [PA_BITS-1:0]         FetchPAdr,
  output logic                       FetchReady,
  input  logic                       DecodeReady,
  output logic                       InstrValidD,
  output logic [WORDLEN-1:0]         InstrD,
  output logic [PA_BITS-1:0]         PAdrD,
  output logic                       CompressedD,
  output logic [PA_BITS-1:0]         PAdrNextD,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WORDLEN-1:0] NOP = WORDLEN'(32'h0000_0013);

  logic [WORDLEN-1:0] word_mem [DEPTH];
  logic [PA_BITS-1:0] padr_mem [DEPTH];
  logic               comp_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic               push, pop;
  logic               fetch_comp;
  logic [WORDLEN-1:0] fetch_word_stored;

  // Status depends only on registered occupancy, so there is no ready/valid loop.
  assign FetchReady  = (count_q != CNT_W'(DEPTH));
  assign InstrValidD = (count_q != '0);
  assign Count       = count_q;

  assign push = FetchValid & FetchReady & ~FlushD;
  assign pop  = InstrValidD & DecodeReady & ~FlushD;

  // Compressed instructions keep only their 16 bits so decode never sees stale upper halves.
  assign fetch_comp        = (FetchWord[1:0] != 2'b11);
  assign fetch_word_stored = fetch_comp ? {{(WORDLEN-16){1'b0}}, FetchWord[15:0]} : FetchWord;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create ordering-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (FlushD) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the entry storage is deliberately not reset; occupancy alone decides
  // validity, and leaving the array reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= fetch_word_stored;
      padr_mem[wr_ptr] <= FetchPAdr;
      comp_mem[wr_ptr] <= fetch_comp;
    end
  end

  // NOTE: every output gets a default before the conditional so no latch is inferred.
  always_comb begin
    InstrD      = NOP;
    PAdrD       = '0;
    CompressedD = 1'b0;
    if (InstrValidD) begin
      InstrD      = word_mem[rd_ptr];
      PAdrD       = padr_mem[rd_ptr];
      CompressedD = comp_mem[rd_ptr];
    end
  end

  assign PAdrNextD = PAdrD + (CompressedD ? PA_BITS'(2) : PA_BITS'(4));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a table of single-cycle vectors followed by
// hand-written full, streaming, flush and async-reset sequences with a scoreboard.
module tb_fetch_queue;

  localparam int PA_BITS = 56;
  localparam int WORDLEN = 32;
  localparam int DEPTH   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               reset;
  logic               FlushD;
  logic               FetchValid;
  logic [WORDLEN-1:0] FetchWord;
  logic [PA_BITS-1:0] FetchPAdr;
  logic               FetchReady;
  logic               DecodeReady;
  logic               InstrValidD;
  logic [WORDLEN-1:0] InstrD;
  logic [PA_BITS-1:0] PAdrD;
  logic               CompressedD;
  logic [PA_BITS-1:0] PAdrNextD;
  logic [2:0]         Count;

  fetch_queue #(.PA_BITS(PA_BITS), .WORDLEN(WORDLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .FlushD      (FlushD),
    .FetchValid  (FetchValid),
    .FetchWord   (FetchWord),
    .FetchPAdr   (FetchPAdr),
    .FetchReady  (FetchReady),
    .DecodeReady (DecodeReady),
    .InstrValidD (InstrValidD),
    .InstrD      (InstrD),
    .PAdrD       (PAdrD),
    .CompressedD (CompressedD),
    .PAdrNextD   (PAdrNextD),
    .Count       (Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               flush;
    logic               fv;
    logic [31:0]        word;
    logic [PA_BITS-1:0] padr;
    logic               dr;
    logic               e_valid;
    logic [31:0]        e_instr;
    logic               e_comp;
    logic [PA_BITS-1:0] e_next;
    logic [2:0]         e_count;
    logic               e_ready;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] expq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic flush, input logic fv, input logic [31:0] word,
                       input logic [PA_BITS-1:0] padr, input logic dr);
    FlushD      = flush;
    FetchValid  = fv;
    FetchWord   = word;
    FetchPAdr   = padr;
    DecodeReady = dr;
  endtask

  // Compare the head entry that decode is about to consume against the scoreboard.
  task automatic sb_pop(input string name);
    logic [31:0] e;
    check({name, "_valid"}, 64'(InstrValidD), 64'd1);
    if (expq.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, InstrD);
    end else begin
      e = expq.pop_front();
      check(name, 64'(InstrD), 64'(e));
    end
  endtask

  function automatic logic [31:0] full_word(input int i);
    return 32'h0010_0013 | (32'(i) << 20);
  endfunction

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h00A0_0093, 56'h8000_0000, 1'b0,
                1'b1, 32'h00A0_0093, 1'b0, 56'h8000_0004, 3'd1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFF_4501, 56'h8000_0006, 1'b1,
                1'b1, 32'h0000_4501, 1'b1, 56'h8000_0008, 3'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 56'h0, 1'b1,
                1'b0, NOP, 1'b0, 56'h4, 3'd0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 56'h0, 1'b1,
                1'b0, NOP, 1'b0, 56'h4, 3'd0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'hABCD_0001, 56'hFF_FFFF_FFFF_FFFE, 1'b0,
                1'b1, 32'h0000_0001, 1'b1, 56'h0, 3'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 32'h1234_5677, 56'h100, 1'b1,
                1'b1, 32'h1234_5677, 1'b0, 56'h104, 3'd1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0093, 56'h200, 1'b0,
                1'b0, NOP, 1'b0, 56'h4, 3'd0, 1'b1};

    // Reset held with fetch activity present.
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h00A0_0093, 56'h8000_0000, 1'b1);
    #12;
    check("rst_instr", 64'(InstrD), 64'(NOP));
    check("rst_count", 64'(Count), 64'd0);
    check("rst_valid", 64'(InstrValidD), 64'd0);
    check("rst_ready", 64'(FetchReady), 64'd1);
    check("rst_next", 64'(PAdrNextD), 64'd4);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].flush, vecs[i].fv, vecs[i].word, vecs[i].padr, vecs[i].dr);
      step();
      check($sformatf("v%0d_valid", i), 64'(InstrValidD), 64'(vecs[i].e_valid));
      check($sformatf("v%0d_instr", i), 64'(InstrD), 64'(vecs[i].e_instr));
      check($sformatf("v%0d_comp", i), 64'(CompressedD), 64'(vecs[i].e_comp));
      check($sformatf("v%0d_next", i), 64'(PAdrNextD), 64'(vecs[i].e_next));
      check($sformatf("v%0d_count", i), 64'(Count), 64'(vecs[i].e_count));
      check($sformatf("v%0d_ready", i), 64'(FetchReady), 64'(vecs[i].e_ready));
    end
    drive(1'b0, 1'b0, 32'h0, 56'h0, 1'b0);
    step();
    check("post_flush_count", 64'(Count), 64'd0);

    // Full / backpressure: five pushes with decode stalled.
    expq.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, full_word(i), 56'h1000 + 56'(4 * i), 1'b0);
      if (i < DEPTH) expq.push_back(full_word(i));
      step();
    end
    check("full_count", 64'(Count), 64'd4);
    check("full_ready", 64'(FetchReady), 64'd0);
    check("full_head", 64'(InstrD), 64'(full_word(0)));
    drive(1'b0, 1'b1, full_word(4), 56'h1010, 1'b1);
    check("full_pop_count_pre", 64'(Count), 64'd4);
    check("full_pop_ready_pre", 64'(FetchReady), 64'd0);
    sb_pop("full_pop0");
    step();
    check("full_after_pop_count", 64'(Count), 64'd3);
    check("full_after_pop_ready", 64'(FetchReady), 64'd1);
    drive(1'b0, 1'b1, full_word(4), 56'h1010, 1'b0);
    expq.push_back(full_word(4));
    step();
    check("full_refill_count", 64'(Count), 64'd4);
    check("full_refill_ready", 64'(FetchReady), 64'd0);
    drive(1'b0, 1'b0, 32'h0, 56'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sb_pop($sformatf("full_drain%0d", i));
      step();
    end
    check("full_drained_count", 64'(Count), 64'd0);

    // Streaming through several pointer wraps with decode always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, full_word(16 + i), 56'h2000 + 56'(4 * i), 1'b1);
      if (i > 0) sb_pop($sformatf("stream%0d", i - 1));
      expq.push_back(full_word(16 + i));
      step();
      check($sformatf("stream_count%0d", i), 64'(Count), 64'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 56'h0, 1'b1);
    sb_pop("stream9");
    step();
    check("stream_end_count", 64'(Count), 64'd0);
    check("stream_sb_empty", 64'(expq.size()), 64'd0);

    // Flush with simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, full_word(40 + i), 56'h3000 + 56'(4 * i), 1'b0);
      step();
    end
    check("flush_pre_count", 64'(Count), 64'd3);
    drive(1'b1, 1'b1, full_word(50), 56'h4000, 1'b1);
    step();
    check("flush_count", 64'(Count), 64'd0);
    check("flush_valid", 64'(InstrValidD), 64'd0);
    check("flush_instr", 64'(InstrD), 64'(NOP));
    drive(1'b0, 1'b0, 32'h0, 56'h0, 1'b0);
    step();
    check("flush_dropped", 64'(Count), 64'd0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, full_word(60 + i), 56'h5000 + 56'(4 * i), 1'b0);
      step();
    end
    check("arst_pre_count", 64'(Count), 64'd2);
    drive(1'b0, 1'b1, full_word(62), 56'h5008, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", 64'(Count), 64'd0);
    check("arst_valid", 64'(InstrValidD), 64'd0);
    check("arst_instr", 64'(InstrD), 64'(NOP));
    check("arst_padr", 64'(PAdrD), 64'd0);
    check("arst_next", 64'(PAdrNextD), 64'd4);
    check("arst_ready", 64'(FetchReady), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 56'h0, 1'b0);
    step();
    reset = 1'b1;
    step();
    check("arst_release_count", 64'(Count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
